// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared definitions for the frame streaming path: default frame geometry,
// pixel format, the FIFO entry layout and the streaming FSM state encoding.
// ---------------------------------------------------------------------------
package video_pkg;

    localparam int IMAGE_WIDTH  = 320;
    localparam int IMAGE_HEIGHT = 240;
    localparam int FRAME_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int ADDR_W       = 17;
    localparam int PIXEL_W      = 12;
    // One FIFO entry carries the pixel plus its start/end-of-packet tags.
    localparam int FIFO_ENTRY_W = PIXEL_W + 2;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        rgb444_t pixel;
        logic    sop;
        logic    eop;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } stream_state_e;

endpackage

// File: rtl/stream_fifo2.sv
// ---------------------------------------------------------------------------
// stream_fifo2
// Two-entry show-ahead FIFO. The oldest entry is always visible on head_o;
// push and pop may happen in the same cycle, including when full.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset, empties the FIFO
//   push_i       write push_data_i this cycle
//   push_data_i  entry to write (pixel + sop + eop)
//   pop_i        discard head this cycle (ignored when empty)
//   head_o       oldest entry (zero after reset)
//   count_o      number of stored entries, 0..2
//   empty_o      count_o == 0
// ---------------------------------------------------------------------------
module stream_fifo2
    import video_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push_i,
    input  fifo_entry_t push_data_i,
    input  logic        pop_i,
    output fifo_entry_t head_o,
    output logic [1:0]  count_o,
    output logic        empty_o
);

    fifo_entry_t mem_q [2];
    fifo_entry_t mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q,  count_d;
    logic        full;
    logic        do_push;
    logic        do_pop;

    assign empty_o = (count_q == 2'd0);
    assign full    = (count_q == 2'd2);
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO can still accept a write when the head leaves in the same cycle.
    assign do_push = push_i && (!full || do_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifndef SYNTHESIS
    // Returning read data with no room and no simultaneous pop means the
    // upstream credit check is broken.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push_i && full && !pop_i));
`endif

endmodule

// File: rtl/frame_stream_source.sv
// ---------------------------------------------------------------------------
// frame_stream_source
// Reads one frame of RGB444 pixels from a frame buffer (1-cycle read
// latency) in row-major order and emits it as a packet stream with
// start/end-of-packet markers.
//
// Handshake: a beat transfers on a rising edge where valid_out && ready_in.
// While valid_out is high and ready_in low, valid_out/data_out/sop/eop hold.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset (deassertion
//                       is expected to be synchronised by the parent)
//   start               request a frame, sampled only while idle
//   busy                frame in progress (cycle after accept .. eop beat)
//   frame_done          one-cycle pulse on the eop handshake
//   rd_en, rd_addr      frame-buffer read strobe and linear address
//   rd_data             pixel returned one cycle after rd_en
//   ready_in            downstream ready
//   valid_out, startofpacket_out, endofpacket_out, data_out
//                       output stream beat
//   dbg_state_o         current FSM state
// ---------------------------------------------------------------------------
module frame_stream_source #(
    parameter int IMAGE_WIDTH  = video_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = video_pkg::IMAGE_HEIGHT,
    parameter int ADDR_W       = video_pkg::ADDR_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          rd_en,
    output logic [ADDR_W-1:0]             rd_addr,
    input  logic [video_pkg::PIXEL_W-1:0] rd_data,
    input  logic                          ready_in,
    output logic                          valid_out,
    output logic                          startofpacket_out,
    output logic                          endofpacket_out,
    output logic [video_pkg::PIXEL_W-1:0] data_out,
    output video_pkg::stream_state_e      dbg_state_o
);

    // ADDR_W must cover the frame: 2**ADDR_W >= IMAGE_WIDTH*IMAGE_HEIGHT.
    localparam int                N_PIX     = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

    video_pkg::stream_state_e state_q, state_d;
    logic [ADDR_W-1:0]        addr_q,  addr_d;
    // The read issued last cycle: its data is on rd_data this cycle.
    logic                     infl_q,     infl_d;
    logic                     infl_sop_q, infl_sop_d;
    logic                     infl_eop_q, infl_eop_d;

    video_pkg::fifo_entry_t   push_entry;
    video_pkg::fifo_entry_t   head;
    logic [1:0]               fifo_count;
    logic                     fifo_empty;
    logic                     handshake;
    logic [2:0]               occupancy;
    logic                     read_ok;

    assign valid_out = !fifo_empty;
    assign handshake = valid_out && ready_in;

    // Entries that will be held after this edge if no new read is issued.
    // Keeping this below 2 before reading guarantees space for every
    // returning pixel, while still allowing one beat per cycle.
    assign occupancy = 3'(fifo_count) + 3'(infl_q) - 3'(handshake);
    assign read_ok   = (occupancy < 3'd2);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_en      = 1'b0;
        infl_d     = 1'b0;
        infl_sop_d = 1'b0;
        infl_eop_d = 1'b0;
        case (state_q)
            video_pkg::ST_IDLE: begin
                if (start) begin
                    state_d = video_pkg::ST_STREAM;
                    addr_d  = '0;
                end
            end
            video_pkg::ST_STREAM: begin
                if (read_ok) begin
                    rd_en      = 1'b1;
                    infl_d     = 1'b1;
                    infl_sop_d = (addr_q == '0);
                    infl_eop_d = (addr_q == LAST_ADDR);
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        state_d = video_pkg::ST_DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            video_pkg::ST_DRAIN: begin
                // start is not looked at here, so a start on the eop
                // handshake cycle is dropped.
                if (handshake && head.eop) begin
                    state_d = video_pkg::ST_IDLE;
                end
            end
            default: begin
                state_d = video_pkg::ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= video_pkg::ST_IDLE;
            addr_q     <= '0;
            infl_q     <= 1'b0;
            infl_sop_q <= 1'b0;
            infl_eop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            infl_q     <= infl_d;
            infl_sop_q <= infl_sop_d;
            infl_eop_q <= infl_eop_d;
        end
    end

    always_comb begin
        push_entry       = '0;
        push_entry.pixel = video_pkg::rgb444_t'(rd_data);
        push_entry.sop   = infl_sop_q;
        push_entry.eop   = infl_eop_q;
    end

    stream_fifo2 u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (infl_q),
        .push_data_i (push_entry),
        .pop_i       (handshake),
        .head_o      (head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    assign rd_addr           = addr_q;
    assign busy              = (state_q != video_pkg::ST_IDLE);
    assign frame_done        = handshake && head.eop;
    assign data_out          = head.pixel;
    assign startofpacket_out = head.sop;
    assign endofpacket_out   = head.eop;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_frame_stream_source.sv
// ---------------------------------------------------------------------------
// tb_frame_stream_source
// 4x2 frame against a 1-cycle-latency RAM model. Expected beats are queued
// when a frame is requested; a negedge monitor pops and compares them on
// every handshake and checks read addresses, outstanding reads, stall
// stability and frame_done.
// ---------------------------------------------------------------------------
module tb_frame_stream_source;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int AW = 3;
    localparam int PW = 12;

    // clock / reset / DUT signals
    logic                     clk;
    logic                     reset_n;
    logic                     start;
    logic                     busy;
    logic                     frame_done;
    logic                     rd_en;
    logic [AW-1:0]            rd_addr;
    logic [PW-1:0]            rd_data;
    logic                     ready_in;
    logic                     valid_out;
    logic                     sop;
    logic                     eop;
    logic [PW-1:0]            data_out;
    video_pkg::stream_state_e dbg_state;

    // scoreboard state
    int              n_cmp;
    int              n_err;
    logic [PW+1:0]   exp_q[$];
    logic [PW-1:0]   ram [N];
    int              ready_mode;   // 0 = held high, 1 = random, 2 = held low
    int              rd_cnt;
    int              out_cnt;
    logic            stall_q;
    logic [PW+1:0]   stall_val;

    frame_stream_source #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .ADDR_W       (AW)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .busy              (busy),
        .frame_done        (frame_done),
        .rd_en             (rd_en),
        .rd_addr           (rd_addr),
        .rd_data           (rd_data),
        .ready_in          (ready_in),
        .valid_out         (valid_out),
        .startofpacket_out (sop),
        .endofpacket_out   (eop),
        .data_out          (data_out),
        .dbg_state_o       (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame buffer: data valid one cycle after rd_en, junk otherwise.
    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_addr];
        else       rd_data <= PW'($urandom);
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_rd_en"},      rd_en,      0);
        check({tag, "_rd_addr"},    rd_addr,    0);
        check({tag, "_valid"},      valid_out,  0);
        check({tag, "_sop"},        sop,        0);
        check({tag, "_eop"},        eop,        0);
        check({tag, "_data"},       data_out,   0);
    endtask

    // Reference frame: pixel i in beat i, sop only on the first, eop only on the last.
    task automatic push_frame();
        for (int i = 0; i < N; i++) begin
            exp_q.push_back({ram[i], 1'(i == 0), 1'(i == N - 1)});
        end
    endtask

    // Pulses start for one edge E; returns at E+1.
    task automatic start_frame(input bit accepted);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (accepted) push_frame();
    endtask

    task automatic wait_drain(input string tag);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 300) begin
            @(posedge clk);
            cyc++;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_idle_busy"},  busy,      0);
        check({tag, "_idle_valid"}, valid_out, 0);
    endtask

    // ---------------- ready driver ----------------
    initial begin
        ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ready_in = 1'b1;
                1:       ready_in = 1'($urandom_range(0, 1));
                default: ready_in = 1'b0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [PW+1:0] e;
        if (!reset_n) begin
            rd_cnt  = 0;
            out_cnt = 0;
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_hold", {valid_out, data_out, sop, eop}, {1'b1, stall_val});
            end
            if (rd_en) begin
                check("rd_addr", rd_addr, rd_cnt);
                check("rd_in_frame", rd_cnt < N, 1);
                rd_cnt++;
                out_cnt++;
            end
            if (valid_out && ready_in) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat", {data_out, sop, eop}, e);
                    check("frame_done", frame_done, e[0]);
                    if (e[0]) rd_cnt = 0;
                end
                out_cnt--;
            end else begin
                check("frame_done_quiet", frame_done, 0);
            end
            check("outstanding_le2", out_cnt <= 2, 1);
            stall_q   = valid_out && !ready_in;
            stall_val = {data_out, sop, eop};
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int reads;
        n_cmp      = 0;
        n_err      = 0;
        start      = 1'b0;
        ready_mode = 0;
        stall_q    = 1'b0;
        rd_cnt     = 0;
        out_cnt    = 0;
        for (int i = 0; i < N; i++) ram[i] = PW'(i);
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;

        // 1: ready held high, cycle-exact timing relative to the start edge
        start_frame(1);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("t1_rd_en_k%0d", k),      rd_en,      k <= 7);
            check($sformatf("t1_valid_k%0d", k),      valid_out,  k >= 2 && k <= 9);
            check($sformatf("t1_frame_done_k%0d", k), frame_done, k == 9);
            check($sformatf("t1_busy_k%0d", k),       busy,       k <= 9);
            @(posedge clk);
            #1;
        end
        wait_drain("t1");

        // 2: random backpressure
        ready_mode = 1;
        start_frame(1);
        wait_drain("t2");

        // 3: ready low for 20 cycles after start
        ready_mode = 2;
        @(posedge clk);
        start_frame(1);
        reads = 0;
        for (int k = 0; k < 20; k++) begin
            if (rd_en) reads++;
            @(posedge clk);
            #1;
        end
        check("t3_reads_le2", reads <= 2, 1);
        check("t3_valid",     valid_out,  1);
        check("t3_data",      data_out,   ram[0]);
        check("t3_sop",       sop,        1);
        check("t3_eop",       eop,        0);
        ready_mode = 0;
        wait_drain("t3");

        // 4: start during beat 3 and on the eop handshake cycle is ignored
        start_frame(1);
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_drain("t4");
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("t4_no_new_read", rd_en,     0);
            check("t4_no_new_beat", valid_out, 0);
        end
        start_frame(1);
        wait_drain("t4b");

        // 5: reset while beat 4 is presented
        start_frame(1);
        repeat (6) @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("t5_reset");
        check("t5_beats_before_reset", exp_q.size(), N - 4);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        start_frame(1);
        wait_drain("t5");

        // 6: random frame contents, random ready, random gaps
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) ram[i] = PW'($urandom_range(0, 4095));
            ready_mode = (f == 1) ? 0 : 1;
            repeat ($urandom_range(0, 5)) @(posedge clk);
            start_frame(1);
            wait_drain($sformatf("t6_f%0d", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
